// File: rtl/pic_periph_pkg.sv
// Shared types and constants for the peripheral interrupt dispatcher.
// Optional rotating priority is selected with PIC_ROTATING_PRIORITY_EN.
package pic_periph_pkg;

  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = 3;

  localparam logic [7:0] DEFAULT_VECTOR_BASE = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    ACK,
    SERVICE
  } state_e;

endpackage

// File: rtl/irq_priority_resolver.sv
// Combinational winner selection over the eligible set, starting the search at rp_i.
// With PIC_ROTATING_PRIORITY_EN undefined the top ties rp_i to zero (bit 0 highest).
module irq_priority_resolver
  import pic_periph_pkg::*;
(
  input  logic [NUM_IRQ-1:0] e_i,
  input  logic [IDX_W-1:0]   rp_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  logic [2*NUM_IRQ-1:0] doubled;
  logic [NUM_IRQ-1:0]   rotated;
  logic [IDX_W-1:0]     offset;

  // Rotate so that bit rp_i lands at position 0, pick the lowest set bit, then undo the rotation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    doubled = {e_i, e_i} >> rp_i;
    rotated = doubled[NUM_IRQ-1:0];
    offset  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDX_W'(i);
    end
  end

  assign winner_o = rp_i + offset;
  assign any_o    = |e_i;

endmodule

// File: rtl/peripheral_irq_dispatcher.sv
// Edge-latched interrupt dispatcher with intr/inta/eoi handshake and one-deep in-service tracking.
// Define PIC_ROTATING_PRIORITY_EN to rotate priority past the last serviced line.
module peripheral_irq_dispatcher
  import pic_periph_pkg::*;
#(
  parameter logic [7:0]  VECTOR_BASE = DEFAULT_VECTOR_BASE,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gie,
  input  logic [7:0] pie,
  input  logic [7:0] irq,
  input  logic       inta,
  input  logic       eoi,
  output logic       intr,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic [7:0] irr_o,
  output logic [7:0] isr_o,
  output logic       busy
);

  localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

  state_e             state_q;
  logic [NUM_IRQ-1:0] irq_q, irr_q, isr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         timer_q;
  logic [7:0]         vector_q;
  logic               intr_q, vector_valid_q, busy_q;

  logic [NUM_IRQ-1:0] edge_set, eligible, idx_onehot, irr_clr, irr_d;
  logic [IDX_W-1:0]   winner, rp;
  logic               any_eligible;

  assign edge_set   = irq & ~irq_q & pie;
  assign eligible   = irr_q & pie;
  assign idx_onehot = NUM_IRQ'(1) << idx_q;
  assign irr_clr    = (state_q == REQUEST && inta) ? idx_onehot : '0;
  // A fresh edge on the line being acknowledged must survive the acknowledge clear.
  assign irr_d      = (irr_q & ~irr_clr) | edge_set;

`ifdef PIC_ROTATING_PRIORITY_EN
  logic [IDX_W-1:0] rp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q <= '0;
    end else if (state_q == SERVICE && eoi) begin
      rp_q <= idx_q + IDX_W'(1);
    end
  end

  assign rp = rp_q;
`else
  assign rp = '0;
`endif

  irq_priority_resolver u_resolver (
    .e_i      (eligible),
    .rp_i     (rp),
    .winner_o (winner),
    .any_o    (any_eligible)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      irq_q          <= '0;
      irr_q          <= '0;
      isr_q          <= '0;
      idx_q          <= '0;
      timer_q        <= '0;
      vector_q       <= '0;
      intr_q         <= 1'b0;
      vector_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      irq_q <= irq;
      irr_q <= irr_d;
      case (state_q)
        IDLE: begin
          if (gie && any_eligible) begin
            idx_q   <= winner;
            timer_q <= '0;
            intr_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= REQUEST;
          end
        end
        REQUEST: begin
          if (inta) begin
            isr_q          <= isr_q | idx_onehot;
            vector_q       <= VECTOR_BASE + {{(8 - IDX_W){1'b0}}, idx_q};
            vector_valid_q <= 1'b1;
            intr_q         <= 1'b0;
            state_q        <= ACK;
          end else if (!gie || !pie[idx_q] || timer_q == TIMER_LAST) begin
            // Abandoned or unanswered: drop intr, leave the request pending for re-arbitration.
            intr_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        ACK: begin
          vector_valid_q <= 1'b0;
          state_q        <= SERVICE;
        end
        SERVICE: begin
          if (eoi) begin
            isr_q   <= isr_q & ~idx_onehot;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign intr         = intr_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign irr_o        = irr_q;
  assign isr_o        = isr_q;
  assign busy         = busy_q;

endmodule
